// File: rtl/trap_controller_if.sv
// Purpose : commit/CSR-side bundle between the pipeline, the CSR file and the trap sequencer.
// Latency : n/a (wires only).
// Backpressure: none in the bundle itself; the controller's busy output tells commit to hold.
//
// Signals:
//   commit_valid, commit_pc, exc_*, mret_valid : commit-stage event requests
//   timer_irq, mstatus_mie                     : interrupt request and global enable
//   mtvec_in, mepc_in                          : current CSR values
//   trap_en, trap_pc, trap_cause               : one-cycle record pulse to the CSR file
//   flush, redirect_valid, redirect_pc, busy   : pipeline control
interface trap_controller_if #(
    parameter int XLEN = 32
);
    logic            commit_valid;
    logic [XLEN-1:0] commit_pc;
    logic            exc_fetch_misaligned;
    logic            exc_illegal;
    logic            exc_ebreak;
    logic            exc_ecall;
    logic            mret_valid;
    logic            timer_irq;
    logic            mstatus_mie;
    logic [XLEN-1:0] mtvec_in;
    logic [XLEN-1:0] mepc_in;

    logic            trap_en;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_cause;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            busy;

    // Pipeline / CSR-file side: drives requests, consumes trap control.
    modport master (
        output commit_valid, commit_pc,
        output exc_fetch_misaligned, exc_illegal, exc_ebreak, exc_ecall,
        output mret_valid, timer_irq, mstatus_mie, mtvec_in, mepc_in,
        input  trap_en, trap_pc, trap_cause,
        input  flush, redirect_valid, redirect_pc, busy
    );

    // Trap controller side.
    modport slave (
        input  commit_valid, commit_pc,
        input  exc_fetch_misaligned, exc_illegal, exc_ebreak, exc_ecall,
        input  mret_valid, timer_irq, mstatus_mie, mtvec_in, mepc_in,
        output trap_en, trap_pc, trap_cause,
        output flush, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/trap_controller.sv
// Purpose : prioritises commit-point exceptions / timer interrupt / MRET and sequences record, flush and redirect.
// Latency : trap: trap_en at N+1, redirect at N+2, idle at N+3; MRET: redirect at N+1, idle at N+2.
// Backpressure: busy is high whenever not idle; events are only sampled in IDLE with commit_valid.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   tc    : trap_controller_if.slave bundle (commit events in, trap record / flush / redirect out)
module trap_controller #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] IRQ_CAUSE = 32'h8000_0007
) (
    input  logic          clk,
    input  logic          rst_n,
    trap_controller_if.slave tc
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        TRAP_REC   = 2'd1,
        TRAP_REDIR = 2'd2,
        RET        = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            trap_en_q, trap_en_d;
    logic [XLEN-1:0] trap_pc_q, trap_pc_d;
    logic [XLEN-1:0] trap_cause_q, trap_cause_d;
    logic            flush_q, flush_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            busy_q, busy_d;

    logic            exc_any;
    logic            irq_take;
    logic [XLEN-1:0] sel_cause;

    assign exc_any  = tc.exc_fetch_misaligned | tc.exc_illegal | tc.exc_ebreak | tc.exc_ecall;
    assign irq_take = tc.timer_irq & tc.mstatus_mie;

    // Fixed priority: exceptions in cause order, then the interrupt.
    always_comb begin
        sel_cause = IRQ_CAUSE;
        if (tc.exc_fetch_misaligned) begin
            sel_cause = XLEN'(4'd0);
        end else if (tc.exc_illegal) begin
            sel_cause = XLEN'(4'd2);
        end else if (tc.exc_ebreak) begin
            sel_cause = XLEN'(4'd3);
        end else if (tc.exc_ecall) begin
            sel_cause = XLEN'(4'd11);
        end
    end

    // Outputs are registered, so each state's outputs are computed one
    // cycle early, in the transition that enters that state.
    always_comb begin
        state_d          = state_q;
        trap_en_d        = 1'b0;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        busy_d           = 1'b0;
        trap_pc_d        = trap_pc_q;
        trap_cause_d     = trap_cause_q;
        redirect_pc_d    = redirect_pc_q;

        unique case (state_q)
            IDLE: begin
                if (tc.commit_valid && (exc_any || irq_take)) begin
                    state_d      = TRAP_REC;
                    trap_en_d    = 1'b1;
                    trap_pc_d    = tc.commit_pc;
                    trap_cause_d = sel_cause;
                    flush_d      = 1'b1;
                    busy_d       = 1'b1;
                end else if (tc.commit_valid && tc.mret_valid) begin
                    state_d          = RET;
                    flush_d          = 1'b1;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = tc.mepc_in;
                    busy_d           = 1'b1;
                end
            end
            TRAP_REC: begin
                // mtvec is taken while trap_en is out, so a write that
                // landed on the edge raising trap_en is already visible.
                state_d          = TRAP_REDIR;
                flush_d          = 1'b1;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = {tc.mtvec_in[XLEN-1:2], 2'b00};
                busy_d           = 1'b1;
            end
            TRAP_REDIR: begin
                state_d = IDLE;
            end
            RET: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            trap_en_q        <= 1'b0;
            trap_pc_q        <= '0;
            trap_cause_q     <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            trap_en_q        <= trap_en_d;
            trap_pc_q        <= trap_pc_d;
            trap_cause_q     <= trap_cause_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            busy_q           <= busy_d;
        end
    end

    assign tc.trap_en        = trap_en_q;
    assign tc.trap_pc        = trap_pc_q;
    assign tc.trap_cause     = trap_cause_q;
    assign tc.flush          = flush_q;
    assign tc.redirect_valid = redirect_valid_q;
    assign tc.redirect_pc    = redirect_pc_q;
    assign tc.busy           = busy_q;

endmodule

// File: tb/tb_trap_controller.sv
// Purpose : directed table-driven check of trap_controller plus hand-written reset/back-to-back sequences.
// Latency : n/a (testbench).
// Backpressure: n/a (testbench).
module tb_trap_controller;

    logic clk;
    logic rst_n;

    trap_controller_if #(.XLEN(32)) tc_if ();

    trap_controller #(.XLEN(32), .IRQ_CAUSE(32'h8000_0007)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tc    (tc_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // One vector = inputs for one clock edge plus the outputs expected just
    // after that edge. ctl = {trap_en, flush, redirect_valid, busy}.
    typedef struct {
        logic        cv;
        logic [31:0] pc;
        logic [3:0]  exc;    // {fetch_misaligned, illegal, ebreak, ecall}
        logic        mret;
        logic        irq;
        logic        mie;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic [3:0]  ctl;
        logic [31:0] tpc;
        logic [31:0] tcause;
        logic [31:0] rpc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic cv, logic [31:0] pc, logic [3:0] exc, logic mret,
                                 logic irq, logic mie, logic [31:0] mtvec, logic [31:0] mepc,
                                 logic [3:0] ctl, logic [31:0] tpc, logic [31:0] tcause,
                                 logic [31:0] rpc);
        vec_t v;
        v.cv = cv; v.pc = pc; v.exc = exc; v.mret = mret; v.irq = irq; v.mie = mie;
        v.mtvec = mtvec; v.mepc = mepc; v.ctl = ctl; v.tpc = tpc; v.tcause = tcause; v.rpc = rpc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        tc_if.commit_valid         = 1'b0;
        tc_if.commit_pc            = '0;
        tc_if.exc_fetch_misaligned = 1'b0;
        tc_if.exc_illegal          = 1'b0;
        tc_if.exc_ebreak           = 1'b0;
        tc_if.exc_ecall            = 1'b0;
        tc_if.mret_valid           = 1'b0;
        tc_if.timer_irq            = 1'b0;
        tc_if.mstatus_mie          = 1'b0;
        tc_if.mtvec_in             = 32'h200;
        tc_if.mepc_in              = 32'h104;
    endtask

    task automatic apply(input vec_t v);
        tc_if.commit_valid         = v.cv;
        tc_if.commit_pc            = v.pc;
        tc_if.exc_fetch_misaligned = v.exc[3];
        tc_if.exc_illegal          = v.exc[2];
        tc_if.exc_ebreak           = v.exc[1];
        tc_if.exc_ecall            = v.exc[0];
        tc_if.mret_valid           = v.mret;
        tc_if.timer_irq            = v.irq;
        tc_if.mstatus_mie          = v.mie;
        tc_if.mtvec_in             = v.mtvec;
        tc_if.mepc_in              = v.mepc;
    endtask

    function automatic logic [31:0] ctl_now();
        return {28'd0, tc_if.trap_en, tc_if.flush, tc_if.redirect_valid, tc_if.busy};
    endfunction

    initial begin
        // ctl nibble: TE=8 FL=4 RV=2 BZ=1
        // 1: illegal at 0x100, mtvec 0x200
        vecs.push_back(mkv(1, 32'h100, 4'b0100, 0, 0, 0, 32'h200, 32'h0,   4'b1101, 32'h100, 32'd2, 32'h0));
        vecs.push_back(mkv(0, 32'h0,   4'b0000, 0, 0, 0, 32'h200, 32'h0,   4'b0111, 32'h0,   32'h0, 32'h200));
        vecs.push_back(mkv(0, 32'h0,   4'b0000, 0, 0, 0, 32'h200, 32'h0,   4'b0000, 32'h0,   32'h0, 32'h0));
        // 2: ecall + illegal together -> cause 2
        vecs.push_back(mkv(1, 32'h40,  4'b0101, 0, 0, 0, 32'h200, 32'h0,   4'b1101, 32'h40,  32'd2, 32'h0));
        vecs.push_back(mkv(0, 32'h0,   4'b0000, 0, 0, 0, 32'h200, 32'h0,   4'b0111, 32'h0,   32'h0, 32'h200));
        vecs.push_back(mkv(0, 32'h0,   4'b0000, 0, 0, 0, 32'h200, 32'h0,   4'b0000, 32'h0,   32'h0, 32'h0));
        // 3: irq masked, irq without commit, then irq taken; mtvec changes to 0x303 in TRAP_REC; irq drops while busy
        vecs.push_back(mkv(1, 32'h80,  4'b0000, 0, 1, 0, 32'h200, 32'h0,   4'b0000, 32'h0,   32'h0, 32'h0));
        vecs.push_back(mkv(0, 32'h80,  4'b0000, 0, 1, 1, 32'h200, 32'h0,   4'b0000, 32'h0,   32'h0, 32'h0));
        vecs.push_back(mkv(1, 32'h80,  4'b0000, 0, 1, 1, 32'h200, 32'h0,   4'b1101, 32'h80,  32'h8000_0007, 32'h0));
        vecs.push_back(mkv(0, 32'h0,   4'b0000, 0, 0, 1, 32'h303, 32'h0,   4'b0111, 32'h0,   32'h0, 32'h300));
        vecs.push_back(mkv(0, 32'h0,   4'b0000, 0, 0, 1, 32'h303, 32'h0,   4'b0000, 32'h0,   32'h0, 32'h0));
        // 4: MRET to 0x104
        vecs.push_back(mkv(1, 32'h90,  4'b0000, 1, 0, 0, 32'h200, 32'h104, 4'b0111, 32'h0,   32'h0, 32'h104));
        vecs.push_back(mkv(0, 32'h0,   4'b0000, 0, 0, 0, 32'h200, 32'h104, 4'b0000, 32'h0,   32'h0, 32'h0));
        // 5: MRET + ebreak -> trap cause 3; ecall during TRAP_REC ignored
        vecs.push_back(mkv(1, 32'h50,  4'b0010, 1, 0, 0, 32'h200, 32'h104, 4'b1101, 32'h50,  32'd3, 32'h0));
        vecs.push_back(mkv(1, 32'h60,  4'b0001, 0, 0, 0, 32'h200, 32'h104, 4'b0111, 32'h0,   32'h0, 32'h200));
        vecs.push_back(mkv(0, 32'h0,   4'b0000, 0, 0, 0, 32'h200, 32'h104, 4'b0000, 32'h0,   32'h0, 32'h0));
        // fetch_misaligned beats illegal; ecall presented during TRAP_REDIR is ignored;
        // event in the first IDLE cycle after the redirect is taken
        vecs.push_back(mkv(1, 32'h10,  4'b1100, 0, 1, 1, 32'h200, 32'h0,   4'b1101, 32'h10,  32'd0, 32'h0));
        vecs.push_back(mkv(0, 32'h0,   4'b0000, 0, 0, 0, 32'h404, 32'h0,   4'b0111, 32'h0,   32'h0, 32'h404));
        vecs.push_back(mkv(1, 32'h14,  4'b0001, 0, 0, 0, 32'h404, 32'h0,   4'b0000, 32'h0,   32'h0, 32'h0));
        vecs.push_back(mkv(1, 32'h18,  4'b0001, 1, 1, 1, 32'h404, 32'h0,   4'b1101, 32'h18,  32'd11, 32'h0));
        vecs.push_back(mkv(0, 32'h0,   4'b0000, 0, 0, 0, 32'h404, 32'h0,   4'b0111, 32'h0,   32'h0, 32'h404));
        vecs.push_back(mkv(0, 32'h0,   4'b0000, 0, 0, 0, 32'h404, 32'h0,   4'b0000, 32'h0,   32'h0, 32'h0));

        drive_idle();
        rst_n = 1'b0;
        #12;
        check("reset_ctl",   ctl_now(),         32'h0);
        check("reset_tpc",   tc_if.trap_pc,     32'h0);
        check("reset_cause", tc_if.trap_cause,  32'h0);
        check("reset_rpc",   tc_if.redirect_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            apply(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ctl", i), ctl_now(), {28'd0, vecs[i].ctl});
            if (vecs[i].ctl[3]) begin
                check($sformatf("v%0d_tpc", i),   tc_if.trap_pc,    vecs[i].tpc);
                check($sformatf("v%0d_cause", i), tc_if.trap_cause, vecs[i].tcause);
            end
            if (vecs[i].ctl[1]) begin
                check($sformatf("v%0d_rpc", i), tc_if.redirect_pc, vecs[i].rpc);
            end
        end

        // Reset asserted mid-trap (during TRAP_REC) clears everything at once.
        @(negedge clk);
        drive_idle();
        tc_if.commit_valid = 1'b1;
        tc_if.commit_pc    = 32'h70;
        tc_if.exc_illegal  = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_pre_ctl", ctl_now(), 32'hD);
        drive_idle();
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctl",   ctl_now(),         32'h0);
        check("rst_mid_tpc",   tc_if.trap_pc,     32'h0);
        check("rst_mid_cause", tc_if.trap_cause,  32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst_quiet%0d", k), ctl_now(), 32'h0);
        end

        // First event after reset is handled from IDLE.
        @(negedge clk);
        tc_if.commit_valid = 1'b1;
        tc_if.commit_pc    = 32'h20;
        tc_if.exc_ecall    = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_te_ctl", ctl_now(),        32'hD);
        check("post_rst_tpc",    tc_if.trap_pc,    32'h20);
        check("post_rst_cause",  tc_if.trap_cause, 32'd11);
        @(negedge clk);
        drive_idle();
        tc_if.mtvec_in = 32'h502;
        @(posedge clk);
        #1;
        check("post_rst_rv_ctl", ctl_now(),         32'h7);
        check("post_rst_rpc",    tc_if.redirect_pc, 32'h500);
        @(posedge clk);
        #1;
        check("post_rst_idle", ctl_now(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
